// File: rtl/pp_rd_arbiter.sv
// Read-request arbiter: picks one pending peripheral group and holds a
// one-hot request to the periplex encoder until ack or ack timeout.
module pp_rd_arbiter #(
  parameter int TOTAL_GRP     = 4,
  parameter int ARB_MODE      = 1,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT       = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TOTAL_GRP-1:0] i_interrupt,
  input  logic [TOTAL_GRP-1:0] i_int_mask,
  input  logic                 rd_req_ack,
  output logic                 rd_req,
  output logic [TOTAL_GRP-1:0] rd_slave_id,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [TOTAL_GRP-1:0] o_timeout_id
);

  localparam int PW = (TOTAL_GRP > 1) ? $clog2(TOTAL_GRP) : 1;
  localparam logic [PW:0] NGRP = (PW+1)'(TOTAL_GRP);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST =
    TIMEOUT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]            r_ptr;
  logic [PW-1:0]            r_win_idx;
  logic [TIMEOUT_WIDTH-1:0] r_timer;
  logic                     r_req;
  logic [TOTAL_GRP-1:0]     r_id;
  logic                     r_busy;
  logic                     r_tmo;
  logic [TOTAL_GRP-1:0]     r_tid;

  logic [TOTAL_GRP-1:0]     w_pending;
  logic [PW-1:0]            w_base;
  logic [2*TOTAL_GRP-1:0]   w_dbl;
  logic [TOTAL_GRP-1:0]     w_rot;
  logic [PW-1:0]            w_off;
  logic [PW:0]              w_sum;
  logic [PW-1:0]            w_win_idx;
  logic [TOTAL_GRP-1:0]     w_win_oh;
  logic [PW:0]              w_inc;
  logic [PW-1:0]            w_nxt_ptr;
  logic                     w_grant;
  logic                     w_rel;
  logic                     w_tmo;

  assign w_pending = i_interrupt & ~i_int_mask;
  assign w_base    = (ARB_MODE == 1) ? r_ptr : '0;

  // Rotate so the pointer's group sits at bit 0, then take the lowest bit.
  always_comb begin
    w_dbl = {w_pending, w_pending} >> w_base;
    w_rot = w_dbl[TOTAL_GRP-1:0];
    w_off = '0;
    for (int i = TOTAL_GRP - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i[PW-1:0];
    end
    w_sum = {1'b0, w_base} + {1'b0, w_off};
    if (w_sum >= NGRP) w_sum = w_sum - NGRP;
    w_win_idx = w_sum[PW-1:0];
    w_win_oh  = TOTAL_GRP'(1) << w_win_idx;
  end

  always_comb begin
    w_inc = {1'b0, r_win_idx} + 1'b1;
    if (w_inc >= NGRP) w_inc = '0;
    w_nxt_ptr = w_inc[PW-1:0];
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_rel   = 1'b0;
    w_tmo   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_pending) begin
          w_grant = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_req_ack) begin
          w_rel  = 1'b1;
          w_next = S_GAP;
        end else if (r_timer == TMO_LAST) begin
          w_rel  = 1'b1;
          w_tmo  = 1'b1;
          w_next = S_GAP;
        end
      end
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_win_idx <= '0;
      r_timer   <= '0;
      r_req     <= 1'b0;
      r_id      <= '0;
      r_busy    <= 1'b0;
      r_tmo     <= 1'b0;
      r_tid     <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_tmo   <= w_tmo;
      if (w_grant) begin
        r_req     <= 1'b1;
        r_id      <= w_win_oh;
        r_win_idx <= w_win_idx;
        r_timer   <= '0;
      end else if (r_state == S_REQ) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_rel) begin
        r_req <= 1'b0;
        r_id  <= '0;
        if (ARB_MODE == 1) r_ptr <= w_nxt_ptr;
      end
      if (w_tmo) r_tid <= r_id;
    end
  end

  assign rd_req       = r_req;
  assign rd_slave_id  = r_id;
  assign o_busy       = r_busy;
  assign o_timeout    = r_tmo;
  assign o_timeout_id = r_tid;

endmodule
